// File: rtl/mlp_pkg.sv
// Shared widths, defaults and state encoding for the MLP inference scheduler.
package mlp_pkg;

    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 16;
    localparam int CLASS_W = 8;
    localparam int CYC_W   = 16;

    localparam logic [ADDR_W-1:0] OUT_BASE_DEF = 12'hC00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_RUN,
        ST_SCAN,
        ST_RESULT
    } sched_state_e;

    function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
        return (v == '1) ? v : v + CYC_W'(1);
    endfunction

endpackage

// File: rtl/argmax_unit.sv
// Running signed maximum and its index over a stream of output-neuron values.
module argmax_unit
    import mlp_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      in_valid,
    input  logic signed [DATA_W-1:0]  in_data,
    input  logic [CLASS_W-1:0]        in_idx,
    output logic signed [DATA_W-1:0]  max_val,
    output logic [CLASS_W-1:0]        max_idx
);

    logic signed [DATA_W-1:0] max_val_q, max_val_d;
    logic [CLASS_W-1:0]       max_idx_q, max_idx_d;

    always_comb begin
        max_val_d = max_val_q;
        max_idx_d = max_idx_q;
        if (clear) begin
            max_val_d = '0;
            max_idx_d = '0;
        end else if (in_valid && ((in_idx == '0) || (in_data > max_val_q))) begin
            // Strictly greater only, so ties stay with the lower index.
            max_val_d = in_data;
            max_idx_d = in_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            max_val_q <= '0;
            max_idx_q <= '0;
        end else begin
            max_val_q <= max_val_d;
            max_idx_q <= max_idx_d;
        end
    end

    assign max_val = max_val_q;
    assign max_idx = max_idx_q;

endmodule

// File: rtl/inference_scheduler.sv
// Sequences one MLP inference: load input neurons, run the core, argmax the
// output layer and hand the result over a valid/ready handshake.
//
// state  | meaning
// IDLE   | waiting for start, core held in reset
// LOAD   | accepting N_IN input words into neuron memory
// START  | one-cycle core_start pulse
// RUN    | core computing, cycle counter running, timeout armed
// SCAN   | reading output layer and tracking the argmax
// RESULT | result_valid held until result_ready
module inference_scheduler
    import mlp_pkg::*;
#(
    parameter int unsigned        N_IN       = 4,
    parameter int unsigned        N_OUT      = 2,
    parameter logic [ADDR_W-1:0]  OUT_BASE   = OUT_BASE_DEF,
    parameter logic [CYC_W-1:0]   MAX_CYCLES = 16'hFFFF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                mem_we,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                core_reset,
    output logic                core_start,
    input  logic                core_done,
    output logic                result_valid,
    input  logic                result_ready,
    output logic [CLASS_W-1:0]  result_class,
    output logic [DATA_W-1:0]   result_score,
    output logic                result_err,
    output logic [CYC_W-1:0]    run_cycles,
    output logic                busy
);

    localparam logic [ADDR_W-1:0] LAST_BEAT = ADDR_W'(N_IN - 1);
    localparam logic [8:0]        SCAN_LAST = 9'(N_OUT);

    sched_state_e        state_q, state_d;
    logic [ADDR_W-1:0]   load_cnt_q, load_cnt_d;
    logic [8:0]          scan_cnt_q, scan_cnt_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                mem_we_q, mem_we_d;
    logic [CYC_W-1:0]    run_cycles_q, run_cycles_d;
    logic                result_err_q, result_err_d;
    logic [CYC_W-1:0]    run_next;

    logic                      am_clear;
    logic                      am_valid;
    logic [CLASS_W-1:0]        am_idx;
    logic signed [DATA_W-1:0]  am_max_val;
    logic [CLASS_W-1:0]        am_max_idx;

    always_comb begin
        state_d      = state_q;
        load_cnt_d   = load_cnt_q;
        scan_cnt_d   = scan_cnt_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_we_d     = 1'b0;
        run_cycles_d = run_cycles_q;
        result_err_d = result_err_q;
        am_clear     = 1'b0;
        am_valid     = 1'b0;
        am_idx       = '0;
        run_next     = sat_inc(run_cycles_q);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_LOAD;
                    load_cnt_d   = '0;
                    run_cycles_d = '0;
                    result_err_d = 1'b0;
                    am_clear     = 1'b1;
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = load_cnt_q;
                    mem_wdata_d = in_data;
                    load_cnt_d  = load_cnt_q + ADDR_W'(1);
                    if (load_cnt_q == LAST_BEAT) begin
                        state_d = ST_START;
                    end
                end
            end
            ST_START: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                run_cycles_d = run_next;
                // core_done wins over a timeout landing in the same cycle.
                if (core_done) begin
                    state_d    = ST_SCAN;
                    scan_cnt_d = '0;
                    mem_addr_d = OUT_BASE;
                end else if (run_next >= MAX_CYCLES) begin
                    state_d      = ST_RESULT;
                    result_err_d = 1'b1;
                end
            end
            ST_SCAN: begin
                scan_cnt_d = scan_cnt_q + 9'd1;
                // Read data trails the address by one cycle, so entry k compares index k-1.
                if (scan_cnt_q != 9'd0) begin
                    am_valid = 1'b1;
                    am_idx   = CLASS_W'(scan_cnt_q - 9'd1);
                end
                if ((scan_cnt_q + 9'd1) < SCAN_LAST) begin
                    mem_addr_d = OUT_BASE + ADDR_W'(scan_cnt_q + 9'd1);
                end
                if (scan_cnt_q == SCAN_LAST) begin
                    state_d = ST_RESULT;
                end
            end
            ST_RESULT: begin
                if (result_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            load_cnt_q   <= '0;
            scan_cnt_q   <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            run_cycles_q <= '0;
            result_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_cnt_q   <= load_cnt_d;
            scan_cnt_q   <= scan_cnt_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
            run_cycles_q <= run_cycles_d;
            result_err_q <= result_err_d;
        end
    end

    argmax_unit u_argmax (
        .clk      (clk),
        .reset    (reset),
        .clear    (am_clear),
        .in_valid (am_valid),
        .in_data  ($signed(mem_rdata)),
        .in_idx   (am_idx),
        .max_val  (am_max_val),
        .max_idx  (am_max_idx)
    );

    assign in_ready     = (state_q == ST_LOAD);
    assign core_reset   = !((state_q == ST_START) || (state_q == ST_RUN));
    assign core_start   = (state_q == ST_START);
    assign busy         = (state_q != ST_IDLE);
    assign result_valid = (state_q == ST_RESULT);
    assign result_class = result_err_q ? '0 : am_max_idx;
    assign result_score = result_err_q ? '0 : am_max_val;
    assign result_err   = result_err_q;
    assign run_cycles   = run_cycles_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_we       = mem_we_q;

endmodule

// File: tb/tb_inference_scheduler.sv
// Directed bench for inference_scheduler: load, run, argmax, timeout and reset.
module tb_inference_scheduler;

    logic        clk;
    logic        reset;
    logic        start, start2;
    logic        in_valid;
    logic [15:0] in_data;
    logic [15:0] mem_rdata;
    logic        core_done, core_done2;
    logic        result_ready;

    logic        in_ready, mem_we, core_reset, core_start, result_valid, result_err, busy;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata, result_score, run_cycles;
    logic [7:0]  result_class;

    logic        t_in_ready, t_mem_we, t_core_reset, t_core_start, t_result_valid, t_result_err, t_busy;
    logic [11:0] t_mem_addr;
    logic [15:0] t_mem_wdata, t_result_score, t_run_cycles;
    logic [7:0]  t_result_class;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] words [4];
    logic [15:0] out_mem [2];

    inference_scheduler dut (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .core_reset(core_reset), .core_start(core_start), .core_done(core_done),
        .result_valid(result_valid), .result_ready(result_ready),
        .result_class(result_class), .result_score(result_score), .result_err(result_err),
        .run_cycles(run_cycles), .busy(busy)
    );

    inference_scheduler #(.MAX_CYCLES(16'd20)) dut_to (
        .clk(clk), .reset(reset), .start(start2),
        .in_valid(in_valid), .in_ready(t_in_ready), .in_data(in_data),
        .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata), .mem_we(t_mem_we), .mem_rdata(mem_rdata),
        .core_reset(t_core_reset), .core_start(t_core_start), .core_done(core_done2),
        .result_valid(t_result_valid), .result_ready(result_ready),
        .result_class(t_result_class), .result_score(t_result_score), .result_err(t_result_err),
        .run_cycles(t_run_cycles), .busy(t_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output-layer memory with one cycle of read latency.
    always @(posedge clk) begin
        if (mem_addr == 12'hC00)      mem_rdata <= out_mem[0];
        else if (mem_addr == 12'hC01) mem_rdata <= out_mem[1];
        else                          mem_rdata <= 16'hDEAD;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".in_ready"},     32'(in_ready),     32'd0);
        check({tag, ".mem_we"},       32'(mem_we),       32'd0);
        check({tag, ".mem_addr"},     32'(mem_addr),     32'd0);
        check({tag, ".mem_wdata"},    32'(mem_wdata),    32'd0);
        check({tag, ".core_reset"},   32'(core_reset),   32'd1);
        check({tag, ".core_start"},   32'(core_start),   32'd0);
        check({tag, ".result_valid"}, 32'(result_valid), 32'd0);
        check({tag, ".result_class"}, 32'(result_class), 32'd0);
        check({tag, ".result_score"}, 32'(result_score), 32'd0);
        check({tag, ".result_err"},   32'(result_err),   32'd0);
        check({tag, ".run_cycles"},   32'(run_cycles),   32'd0);
        check({tag, ".busy"},         32'(busy),         32'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("load.in_ready", 32'(in_ready), 32'd1);
        check("load.busy",     32'(busy),     32'd1);
    endtask

    // Ends at the negedge where the scheduler sits in START.
    task automatic load_words(input bit gaps);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = words[i];
            @(negedge clk);
            in_valid = 1'b0;
            check("wr.we",         32'(mem_we),     32'd1);
            check("wr.addr",       32'(mem_addr),   32'(i));
            check("wr.data",       32'(mem_wdata),  32'(words[i]));
            check("wr.in_ready",   32'(in_ready),   32'(i < 3));
            check("wr.core_start", 32'(core_start), 32'(i == 3));
            check("wr.core_reset", 32'(core_reset), 32'(i != 3));
            if (gaps && i < 3) begin
                @(negedge clk);
                check("gap.we", 32'(mem_we), 32'd0);
            end
        end
    endtask

    // Called in START; raises core_done during RUN cycle n, ends in SCAN entry.
    task automatic run_for(input int n);
        @(negedge clk);
        core_done = 1'b0;
        check("run1.core_start", 32'(core_start), 32'd0);
        check("run1.core_reset", 32'(core_reset), 32'd0);
        check("run1.mem_we",     32'(mem_we),     32'd0);
        repeat (n - 1) @(negedge clk);
        check("run.pre_cycles", 32'(run_cycles), 32'(n - 1));
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        check("scan0.run_cycles", 32'(run_cycles), 32'(n));
        check("scan0.addr",       32'(mem_addr),   32'h0C00);
        check("scan0.core_reset", 32'(core_reset), 32'd1);
    endtask

    task automatic scan_expect(input logic [7:0] cls, input logic [15:0] score);
        @(negedge clk);
        check("scan1.addr",  32'(mem_addr),     32'h0C01);
        check("scan1.valid", 32'(result_valid), 32'd0);
        @(negedge clk);
        check("scan2.valid", 32'(result_valid), 32'd0);
        @(negedge clk);
        check("res.valid", 32'(result_valid), 32'd1);
        check("res.class", 32'(result_class), 32'(cls));
        check("res.score", 32'(result_score), 32'(score));
        check("res.err",   32'(result_err),   32'd0);
        check("res.we",    32'(mem_we),       32'd0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; start2 = 1'b0; in_valid = 1'b0; in_data = '0;
        core_done = 1'b0; core_done2 = 1'b0; result_ready = 1'b0;
        out_mem[0] = '0; out_mem[1] = '0;

        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        reset = 1'b1;
        @(negedge clk);
        check("idle.busy", 32'(busy), 32'd0);

        // Inference 1: gapped load, core_done held high outside RUN, class 1 wins.
        words[0] = 16'h0010; words[1] = 16'h0020; words[2] = 16'h0030; words[3] = 16'h0040;
        out_mem[0] = 16'hFF00; out_mem[1] = 16'h0005;
        core_done = 1'b1;
        @(negedge clk);
        check("idle.done_ignored", 32'(busy), 32'd0);
        pulse_start();
        load_words(1'b1);
        run_for(37);
        check("scan0.run_cycles37", 32'(run_cycles), 32'd37);
        scan_expect(8'd1, 16'h0005);

        // Hold in RESULT with start pulses, all must be ignored.
        for (int i = 0; i < 10; i++) begin
            start = (i % 3 == 0);
            @(negedge clk);
            check("hold.valid", 32'(result_valid), 32'd1);
            check("hold.class", 32'(result_class), 32'd1);
            check("hold.score", 32'(result_score), 32'h0005);
        end
        start = 1'b0;
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        check("ack.valid", 32'(result_valid), 32'd0);
        check("ack.busy",  32'(busy),         32'd0);
        @(negedge clk);
        check("ack.stay_idle", 32'(busy), 32'd0);

        // Inference 2: back-to-back load, equal outputs keep index 0.
        words[0] = 16'h1234; words[1] = 16'hABCD; words[2] = 16'h0000; words[3] = 16'h7FFF;
        out_mem[0] = 16'h0100; out_mem[1] = 16'h0100;
        pulse_start();
        check("load2.run_cleared", 32'(run_cycles), 32'd0);
        load_words(1'b0);
        run_for(5);
        scan_expect(8'd0, 16'h0100);
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        check("ack2.valid", 32'(result_valid), 32'd0);

        // Reset mid-LOAD.
        pulse_start();
        in_valid = 1'b1; in_data = 16'h5555;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("rst_load.busy",     32'(busy),     32'd0);
        check("rst_load.in_ready", 32'(in_ready), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Reset mid-RUN with result_ready low, then no further writes.
        words[0] = 16'h0001; words[1] = 16'h0002; words[2] = 16'h0003; words[3] = 16'h0004;
        pulse_start();
        load_words(1'b0);
        repeat (6) @(negedge clk);
        check("midrun.busy",  32'(busy),       32'd1);
        check("midrun.count", 32'(run_cycles), 32'd5);
        reset = 1'b0;
        @(negedge clk);
        check_reset_vals("rst_run");
        reset = 1'b1;
        in_valid = 1'b1; in_data = 16'h0F0F;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_rst.we",   32'(mem_we), 32'd0);
            check("post_rst.busy", 32'(busy),   32'd0);
        end
        in_valid = 1'b0;

        // Timeout on the MAX_CYCLES=20 instance.
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        check("to.in_ready", 32'(t_in_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 16'(16'h0100 + i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("to.core_start",   32'(t_core_start), 32'd1);
        check("to.last_wr_addr", 32'(t_mem_addr),   32'd3);
        check("to.main_no_we",   32'(mem_we),       32'd0);
        @(negedge clk);
        check("to.run1", 32'(t_run_cycles), 32'd0);
        repeat (19) @(negedge clk);
        check("to.run20_cnt",   32'(t_run_cycles),   32'd19);
        check("to.run20_valid", 32'(t_result_valid), 32'd0);
        @(negedge clk);
        check("to.valid",      32'(t_result_valid), 32'd1);
        check("to.err",        32'(t_result_err),   32'd1);
        check("to.class",      32'(t_result_class), 32'd0);
        check("to.score",      32'(t_result_score), 32'd0);
        check("to.cycles",     32'(t_run_cycles),   32'd20);
        check("to.core_reset", 32'(t_core_reset),   32'd1);
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        check("to.ack_valid", 32'(t_result_valid), 32'd0);
        check("to.ack_busy",  32'(t_busy),         32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
